// File: rtl/instr_fetch.sv
// Single-outstanding instruction fetch stage: request, hold for decode, wait for next PC.
// Optional macro FETCH_ALIGN_CHECK_EN: misaligned targets raise a sticky fetch_fault instead of being truncated.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      next_pc,
  input  logic             next_pc_valid,
  input  logic             flush,
  output logic [31:0]      pc,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic             imem_ack,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      instr,
  output logic [31:0]      instr_pc,
  output logic             instr_valid,
  input  logic             instr_ready,
  output logic [CNT_W-1:0] fetch_count,
  output logic             fetch_fault
);

  typedef enum logic [2:0] {IDLE, FETCH, HOLD, WAIT_PC, DRAIN} state_t;

  state_t             state_q, state_d;
  logic [31:0]        pc_q, pc_d, pend_q, pend_d;
  logic [31:0]        instr_q, instr_d, ipc_q, ipc_d;
  logic               vld_q, vld_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               fault_q, fault_d;
  logic               tgt_load;
  logic [31:0]        tgt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      pend_q  <= '0;
      instr_q <= '0;
      ipc_q   <= '0;
      vld_q   <= 1'b0;
      cnt_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
      vld_q   <= vld_d;
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    pend_d   = pend_q;
    instr_d  = instr_q;
    ipc_d    = ipc_q;
    vld_d    = vld_q;
    cnt_d    = cnt_q;
    fault_d  = fault_q;
    tgt_load = 1'b0;
    tgt      = next_pc;
    case (state_q)
      IDLE: begin
        if (flush) tgt_load = 1'b1;
        else       state_d  = FETCH;
      end
      FETCH: begin
        if (flush) begin
          if (imem_ack) tgt_load = 1'b1;
          else begin
            pend_d  = next_pc;
            state_d = DRAIN;
          end
        end else if (imem_ack) begin
          instr_d = imem_rdata;
          ipc_d   = pc_q;
          vld_d   = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (flush) begin
          vld_d    = 1'b0;
          tgt_load = 1'b1;
        end else if (vld_q && instr_ready) begin
          vld_d   = 1'b0;
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = WAIT_PC;
        end
      end
      WAIT_PC: begin
        if (flush || next_pc_valid) tgt_load = 1'b1;
      end
      DRAIN: begin
        // A flush arriving with the ack is newer than the stored target.
        if (imem_ack) begin
          tgt_load = 1'b1;
          if (!flush) tgt = pend_q;
        end else if (flush) begin
          pend_d = next_pc;
        end
      end
      default: state_d = IDLE;
    endcase
`ifdef FETCH_ALIGN_CHECK_EN
    if (flush && next_pc[1:0] == 2'b00) fault_d = 1'b0;
    if (tgt_load) begin
      pc_d = tgt;
      if (tgt[1:0] != 2'b00) begin
        fault_d = 1'b1;
        state_d = WAIT_PC;
      end else begin
        state_d = FETCH;
      end
    end
`else
    if (tgt_load) begin
      pc_d    = tgt & ~32'h3;
      state_d = FETCH;
    end
`endif
  end

  assign pc          = pc_q;
  assign imem_req    = (state_q == FETCH) || (state_q == DRAIN);
  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign instr_pc    = ipc_q;
  assign instr_valid = vld_q;
  assign fetch_count = cnt_q;
`ifdef FETCH_ALIGN_CHECK_EN
  assign fetch_fault = fault_q;
`else
  assign fetch_fault = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: accepted fetches are queued and checked at the decode handshake.
module tb_instr_fetch;
  logic        clk = 1'b0;
  logic        reset, next_pc_valid, flush, imem_ack, instr_ready;
  logic [31:0] next_pc, imem_rdata;
  logic [31:0] pc, imem_addr, instr, instr_pc;
  logic        imem_req, instr_valid, fetch_fault;
  logic [3:0]  fetch_count;

  int checks = 0, errors = 0;
  typedef struct packed { logic [31:0] ins; logic [31:0] pc; } exp_t;
  exp_t       sb[$];
  logic [3:0] exp_cnt = '0;

  instr_fetch #(.RESET_PC(32'h0), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .next_pc(next_pc), .next_pc_valid(next_pc_valid),
    .flush(flush), .pc(pc), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr(instr), .instr_pc(instr_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .fetch_count(fetch_count),
    .fetch_fault(fetch_fault));

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk); #1;
  endtask

  // Expects the DUT in FETCH at addr; acks after `delay` idle request cycles.
  task automatic fetch_word(input logic [31:0] addr, input logic [31:0] data, input int delay);
    for (int i = 0; i <= delay; i++) begin
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== addr) begin
        errors++;
        $display("FAIL fetch_req req=%b addr=%h expected req=1 addr=%h", imem_req, imem_addr, addr);
      end
      if (i < delay) step();
    end
    imem_ack = 1'b1; imem_rdata = data;
    sb.push_back('{data, addr});
    step();
    imem_ack = 1'b0; imem_rdata = $urandom;
  endtask

  task automatic deliver(input int hold);
    exp_t e;
    instr_ready = 1'b0;
    checks++;
    if (instr_valid !== 1'b1 || sb.size() == 0) begin
      errors++;
      $display("FAIL deliver_valid valid=%b queued=%0d expected valid=1", instr_valid, sb.size());
      return;
    end
    e = sb[0];
    for (int i = 0; i < hold; i++) begin
      step();
      checks++;
      if (instr_valid !== 1'b1 || instr !== e.ins || instr_pc !== e.pc ||
          imem_req !== 1'b0 || fetch_count !== exp_cnt) begin
        errors++;
        $display("FAIL hold_stable v=%b instr=%h pc=%h req=%b cnt=%0d expected 1 %h %h 0 %0d",
                 instr_valid, instr, instr_pc, imem_req, fetch_count, e.ins, e.pc, exp_cnt);
      end
    end
    e = sb.pop_front();
    checks++;
    if (instr !== e.ins || instr_pc !== e.pc) begin
      errors++;
      $display("FAIL handshake_data instr=%h pc=%h expected %h %h", instr, instr_pc, e.ins, e.pc);
    end
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    exp_cnt++;
    checks++;
    if (instr_valid !== 1'b0 || fetch_count !== exp_cnt || imem_req !== 1'b0) begin
      errors++;
      $display("FAIL after_handshake v=%b cnt=%0d req=%b expected 0 %0d 0",
               instr_valid, fetch_count, imem_req, exp_cnt);
    end
  endtask

  task automatic next(input logic [31:0] a);
    next_pc = a; next_pc_valid = 1'b1;
    step();
    next_pc_valid = 1'b0;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== a) begin
      errors++;
      $display("FAIL next_pc req=%b addr=%h expected 1 %h", imem_req, imem_addr, a);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; next_pc = '0; next_pc_valid = 0; flush = 0; imem_ack = 0;
    imem_rdata = '0; instr_ready = 0;
    #2;
    checks++;
    if (pc !== 32'h0 || imem_req !== 1'b0 || imem_addr !== 32'h0 || instr !== 32'h0 ||
        instr_pc !== 32'h0 || instr_valid !== 1'b0 || fetch_count !== 4'd0 || fetch_fault !== 1'b0) begin
      errors++;
      $display("FAIL reset_state pc=%h req=%b addr=%h instr=%h ipc=%h v=%b cnt=%0d fault=%b expected all 0",
               pc, imem_req, imem_addr, instr, instr_pc, instr_valid, fetch_count, fetch_fault);
    end
    step();
    reset = 1'b0;
    checks++;
    if (imem_req !== 1'b0) begin
      errors++;
      $display("FAIL idle_req req=%b expected 0", imem_req);
    end
    step();
  endtask

  task automatic test_basic;
    fetch_word(32'h0, 32'hE3A0_0001, 1);
    deliver(0);
    checks++;
    if (fetch_count !== 4'd1) begin
      errors++;
      $display("FAIL basic_count cnt=%0d expected 1", fetch_count);
    end
    next(32'h4);
  endtask

  task automatic test_hold;
    fetch_word(32'h4, $urandom, 0);
    deliver(5);
    next(32'h8);
  endtask

  task automatic test_flush_drain;
    next_pc = 32'h100; flush = 1'b1;
    step();
    flush = 1'b0; next_pc = 32'h0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h8 || instr_valid !== 1'b0) begin
        errors++;
        $display("FAIL drain_hold req=%b addr=%h v=%b expected 1 00000008 0", imem_req, imem_addr, instr_valid);
      end
      if (i == 2) begin imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF; end
      step();
    end
    imem_ack = 1'b0;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h100 || instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL drain_redirect req=%b addr=%h v=%b expected 1 00000100 0", imem_req, imem_addr, instr_valid);
    end
    fetch_word(32'h100, $urandom, 0);
    deliver(0);
    next(32'h4);
  endtask

  task automatic test_flush_ack;
    next_pc = 32'h40; flush = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hBAD0_BAD0;
    step();
    flush = 1'b0; imem_ack = 1'b0;
    checks++;
    if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h40) begin
      errors++;
      $display("FAIL flush_ack v=%b req=%b addr=%h expected 0 1 00000040", instr_valid, imem_req, imem_addr);
    end
    fetch_word(32'h40, $urandom, 2);
    deliver(1);
    next(32'h44);
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 13; i++) begin
      fetch_word(32'h44 + 32'(4 * i), $urandom, i % 3);
      deliver(0);
      next(32'h48 + 32'(4 * i));
    end
    checks++;
    if (fetch_count !== 4'd1) begin
      errors++;
      $display("FAIL count_wrap cnt=%0d expected 1", fetch_count);
    end
  endtask

  task automatic test_misalign;
    fetch_word(32'h78, $urandom, 0);
    deliver(0);
    next_pc = 32'h102; next_pc_valid = 1'b1;
    step();
    next_pc_valid = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
    step();
    checks++;
    if (fetch_fault !== 1'b1 || imem_req !== 1'b0) begin
      errors++;
      $display("FAIL misalign_fault fault=%b req=%b expected 1 0", fetch_fault, imem_req);
    end
    next_pc = 32'h200; flush = 1'b1;
    step();
    flush = 1'b0;
    checks++;
    if (fetch_fault !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h200) begin
      errors++;
      $display("FAIL fault_clear fault=%b req=%b addr=%h expected 0 1 00000200", fetch_fault, imem_req, imem_addr);
    end
`else
    checks++;
    if (fetch_fault !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h100) begin
      errors++;
      $display("FAIL misalign_trunc fault=%b req=%b addr=%h expected 0 1 00000100", fetch_fault, imem_req, imem_addr);
    end
    fetch_word(32'h100, $urandom, 0);
    deliver(0);
    next(32'h200);
`endif
  endtask

  task automatic test_reset_mid;
    next_pc = 32'h300; flush = 1'b1;
    step();
    flush = 1'b0;
    reset = 1'b1; imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
    #1;
    checks++;
    if (imem_req !== 1'b0 || pc !== 32'h0 || fetch_count !== 4'd0 || instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL async_reset req=%b pc=%h cnt=%0d v=%b expected 0 0 0 0", imem_req, pc, fetch_count, instr_valid);
    end
    exp_cnt = '0;
    step();
    reset = 1'b0;
    step();
    imem_ack = 1'b0;
    checks++;
    if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      errors++;
      $display("FAIL late_ack v=%b req=%b addr=%h expected 0 1 00000000", instr_valid, imem_req, imem_addr);
    end
    fetch_word(32'h0, $urandom, 0);
    next_pc = 32'h80; flush = 1'b1;
    step();
    flush = 1'b0;
    void'(sb.pop_front());
    checks++;
    if (instr_valid !== 1'b0 || fetch_count !== 4'd0 || imem_req !== 1'b1 || imem_addr !== 32'h80) begin
      errors++;
      $display("FAIL hold_flush v=%b cnt=%0d req=%b addr=%h expected 0 0 1 00000080",
               instr_valid, fetch_count, imem_req, imem_addr);
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_left queued=%0d expected 0", sb.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_hold();
    test_flush_drain();
    test_flush_ack();
    test_back_to_back();
    test_misalign();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the PC loaded on reset.
REQ-002 SHALL have parameter CNT_W, default 16, the width of fetch_count.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port next_pc, input, 32, next PC from the next-PC stage.
REQ-006 SHALL have port next_pc_valid, input, 1, next_pc usable this cycle.
REQ-007 SHALL have port flush, input, 1, redirect: discard buffered/in-flight fetch, target = next_pc.
REQ-008 SHALL have port pc, output, 32, current PC fed back to the next-PC stage.
REQ-009 SHALL have port imem_req, output, 1, instruction-memory request.
REQ-010 SHALL have port imem_addr, output, 32, request address.
REQ-011 SHALL have port imem_ack, input, 1, memory returns imem_rdata this cycle.
REQ-012 SHALL have port imem_rdata, input, 32, fetched word.
REQ-013 SHALL have port instr, output, 32, instruction to decode.
REQ-014 SHALL have port instr_pc, output, 32, address of instr.
REQ-015 SHALL have port instr_valid, output, 1, instr/instr_pc valid.
REQ-016 SHALL have port instr_ready, input, 1, decode accepts this cycle.
REQ-017 SHALL have port fetch_count, output, CNT_W, count of delivered instructions.
REQ-018 SHALL have port fetch_fault, output, 1, misaligned target (FETCH_ALIGN_CHECK_EN only; else tied 0).

Function
REQ-019 SHALL implement states IDLE, FETCH, HOLD, WAIT_PC, DRAIN.
REQ-020 IDLE SHALL go to FETCH on the next clock unconditionally.
REQ-021 In FETCH, imem_req SHALL be 1 and imem_addr SHALL equal pc, both held stable until imem_ack.
REQ-022 FETCH with imem_ack SHALL register instr=imem_rdata, instr_pc=pc, instr_valid=1 and go to HOLD (one-cycle ack-to-valid latency).
REQ-023 In HOLD, instr/instr_pc SHALL stay stable; on instr_valid&instr_ready, instr_valid SHALL clear, fetch_count SHALL increment, and state SHALL go to WAIT_PC.
REQ-024 In WAIT_PC, on next_pc_valid pc SHALL load next_pc and state SHALL go to FETCH; otherwise it holds.
REQ-025 flush in IDLE, HOLD or WAIT_PC SHALL clear instr_valid, load pc=next_pc, go to FETCH; no handshake or count that cycle.
REQ-026 flush in FETCH with imem_ack SHALL discard imem_rdata, load pc=next_pc, go to FETCH.
REQ-027 flush in FETCH without imem_ack SHALL store next_pc as pending target and go to DRAIN, keeping imem_req=1 and old imem_addr.
REQ-028 DRAIN on imem_ack SHALL discard data, load pc=pending target, go to FETCH; a further flush in DRAIN SHALL overwrite the pending target.
REQ-029 fetch_count SHALL wrap from all-ones to 0.
REQ-030 imem_req SHALL be 0 in IDLE, HOLD and WAIT_PC.

Reset
REQ-031 reset SHALL immediately force state=IDLE, pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, instr=0, instr_pc=0, instr_valid=0, fetch_count=0, fetch_fault=0, pending target=0.
REQ-032 Reset mid-DRAIN/FETCH SHALL abandon the transaction; a late imem_ack after reset SHALL be ignored outside FETCH/DRAIN.

Configuration
REQ-033 With macro FETCH_ALIGN_CHECK_EN defined, loading a target with bits[1:0]!=0 SHALL set fetch_fault=1 (sticky until reset or an aligned flush), go to WAIT_PC, and issue no request.
REQ-034 Without FETCH_ALIGN_CHECK_EN, target bits[1:0] SHALL be forced to 0 when loaded into pc and fetch_fault SHALL be constant 0.

Verification
REQ-035 Reset release, RESET_PC=0, ack one cycle after req with rdata=32'hE3A0_0001, instr_ready=1 -> imem_addr=0, instr_valid with instr=32'hE3A0_0001, instr_pc=0, fetch_count=1.
REQ-036 instr_ready=0 for 5 cycles in HOLD -> instr/instr_pc stable, imem_req=0, fetch_count unchanged.
REQ-037 flush with next_pc=32'h100 while FETCH at pc=8, ack 3 cycles later -> DRAIN, data discarded, next request imem_addr=32'h100.
REQ-038 flush with next_pc=32'h40 same cycle as imem_ack at pc=4 -> no instr_valid, next request imem_addr=32'h40.
REQ-039 CNT_W=4, 17 deliveries -> fetch_count=1 after wrap.
REQ-040 next_pc=32'h102 after delivery -> with FETCH_ALIGN_CHECK_EN fetch_fault=1, imem_req=0; without it imem_addr=32'h100.
